// File: rtl/afe_spi_pkg.sv
// Shared definitions for the AFE SPI sequencer and its round-robin arbiter.
//   seq_state_t    : serializer state encoding
//   clog2()        : ceiling log2 for sizing counters and pointers
//   *_MIN / *_MAX  : legal ranges for DATA_WIDTH and CLK_DIV
package afe_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LATCH = 3'd4,
    ST_GAP   = 3'd5
  } seq_state_t;

  localparam int DATA_WIDTH_MIN = 8;
  localparam int DATA_WIDTH_MAX = 32;
  localparam int CLK_DIV_MIN    = 1;

  // Ceiling log2; clog2(1) is 0, so callers sizing a vector clamp to 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/afe_spi_sequencer_rr_arbiter.sv
// Round-robin arbiter for any shared resource.
//   clk     : clock
//   srst    : synchronous active-high reset (requester 0 gets top priority)
//   req     : request vector
//   advance : grant was taken this cycle; move priority past the winner
//   grant   : one-hot grant, combinational from req and the pointer
module rr_arbiter
  import afe_spi_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            srst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int PTR_W = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);

  // ptr_reg holds the index that currently has highest priority.
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    grant    = '0;
    ptr_next = ptr_reg;
    // Walk from the pointer with wrap-around; first requester wins.
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = (idx + 1 >= NREQ) ? '0 : PTR_W'(idx + 1);
      end
    end
    // A request withdrawn before being taken leaves priority untouched.
    if (!advance) begin
      ptr_next = ptr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/afe_spi_sequencer.sv
// Arbitrates write requests onto the AFE attenuator/switch SPI chains and
// serializes each word MSB-first, then pulses the chain's latch enable.
//   sysClk/sysReset : clock, synchronous active-high reset
//   reqValid/Ready  : per-requester handshake; reqReady is a one-hot grant
//   reqData/reqSel  : per-requester word and target chain (slice i)
//   reqDone         : one-cycle strobe back to the finished requester
//   busy            : transaction in progress
//   selError        : sticky, an accepted request targeted a missing chain
//   spiClk/Sdi/Le   : per-chain SPI pins, only the selected chain moves
module afe_spi_sequencer
  import afe_spi_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int NSPI       = 2,
  parameter int SEL_WIDTH  = 1,
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 10
) (
  input  logic                         sysClk,
  input  logic                         sysReset,
  input  logic [NREQ-1:0]              reqValid,
  output logic [NREQ-1:0]              reqReady,
  input  logic [NREQ*DATA_WIDTH-1:0]   reqData,
  input  logic [NREQ*SEL_WIDTH-1:0]    reqSel,
  output logic [NREQ-1:0]              reqDone,
  output logic                         busy,
  output logic                         selError,
  output logic [NSPI-1:0]              spiClk,
  output logic [NSPI-1:0]              spiSdi,
  output logic [NSPI-1:0]              spiLe
);

  localparam int CD    = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;
  localparam int CNT_W = (clog2(CD) < 1) ? 1 : clog2(CD);
  localparam int BIT_W = (clog2(DATA_WIDTH) < 1) ? 1 : clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  seq_state_t            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [SEL_WIDTH-1:0]  sel_reg, sel_next;
  logic [NREQ-1:0]       owner_reg, owner_next;
  logic [NREQ-1:0]       done_reg, done_next;
  logic                  busy_reg, busy_next;
  logic                  sel_error_reg, sel_error_next;
  logic [NSPI-1:0]       spi_clk_reg, spi_clk_next;
  logic [NSPI-1:0]       spi_sdi_reg, spi_sdi_next;
  logic [NSPI-1:0]       spi_le_reg, spi_le_next;

  logic [NREQ-1:0]       grant;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_in;
  logic [SEL_WIDTH-1:0]  sel_in;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arbiter (
    .clk     (sysClk),
    .srst    (sysReset),
    .req     (reqValid),
    .advance (accept),
    .grant   (grant)
  );

  // Ready is the only combinational output: a grant is offered in IDLE only.
  assign reqReady = (state_reg == ST_IDLE && !sysReset) ? grant : '0;
  assign accept   = |(reqValid & reqReady);

  always_comb begin
    data_in = '0;
    sel_in  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        data_in = reqData[i*DATA_WIDTH +: DATA_WIDTH];
        sel_in  = reqSel[i*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    sel_next       = sel_reg;
    owner_next     = owner_reg;
    sel_error_next = sel_error_reg;

    if (state_reg == ST_IDLE) begin
      if (accept) begin
        state_next     = ST_LOW;
        cnt_next       = '0;
        bit_next       = '0;
        shift_next     = data_in;
        sel_next       = sel_in;
        owner_next     = reqReady;
        sel_error_next = sel_error_reg | (32'(sel_in) >= 32'(NSPI));
      end
    end else if (cnt_reg != CNT_LAST) begin
      cnt_next = cnt_reg + 1'b1;
    end else begin
      cnt_next = '0;
      case (state_reg)
        ST_LOW:  state_next = ST_HIGH;
        ST_HIGH: begin
          if (bit_reg == BIT_LAST) begin
            state_next = ST_HOLD;
          end else begin
            state_next = ST_LOW;
            bit_next   = bit_reg + 1'b1;
            shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
          end
        end
        ST_HOLD:  state_next = ST_LATCH;
        ST_LATCH: state_next = ST_GAP;
        ST_GAP:   state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_GAP && cnt_next == CNT_LAST) ? owner_next : '0;
  end

  // An out-of-range select matches no chain, so the sequence runs silently.
  genvar gi;
  generate
    for (gi = 0; gi < NSPI; gi++) begin : g_chain
      logic hit;
      assign hit              = (sel_next == SEL_WIDTH'(gi));
      assign spi_clk_next[gi] = hit && (state_next == ST_HIGH);
      assign spi_sdi_next[gi] = hit && (state_next == ST_LOW || state_next == ST_HIGH)
                                && shift_next[DATA_WIDTH-1];
      assign spi_le_next[gi]  = hit && (state_next == ST_LATCH);
    end
  endgenerate

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      sel_reg       <= '0;
      owner_reg     <= '0;
      done_reg      <= '0;
      busy_reg      <= 1'b0;
      sel_error_reg <= 1'b0;
      spi_clk_reg   <= '0;
      spi_sdi_reg   <= '0;
      spi_le_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      sel_reg       <= sel_next;
      owner_reg     <= owner_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      sel_error_reg <= sel_error_next;
      spi_clk_reg   <= spi_clk_next;
      spi_sdi_reg   <= spi_sdi_next;
      spi_le_reg    <= spi_le_next;
    end
  end

  assign reqDone  = done_reg;
  assign busy     = busy_reg;
  assign selError = sel_error_reg;
  assign spiClk   = spi_clk_reg;
  assign spiSdi   = spi_sdi_reg;
  assign spiLe    = spi_le_reg;

endmodule

// File: tb/tb_afe_spi_sequencer.sv
module tb_afe_spi_sequencer;

  logic        sysClk = 1'b0;
  logic        sysReset;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [47:0] reqData;
  logic [3:0]  reqSel;
  logic [1:0]  reqDone;
  logic        busy;
  logic        selError;
  logic [1:0]  spiClk;
  logic [1:0]  spiSdi;
  logic [1:0]  spiLe;

  int checks = 0;
  int errors = 0;

  afe_spi_sequencer #(
    .NREQ(2), .NSPI(2), .SEL_WIDTH(2), .DATA_WIDTH(24), .CLK_DIV(2)
  ) dut (
    .sysClk(sysClk), .sysReset(sysReset), .reqValid(reqValid), .reqReady(reqReady),
    .reqData(reqData), .reqSel(reqSel), .reqDone(reqDone), .busy(busy),
    .selError(selError), .spiClk(spiClk), .spiSdi(spiSdi), .spiLe(spiLe)
  );

  always #5 sysClk = ~sysClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [23:0] d, input logic [1:0] s);
    reqData[r*24 +: 24] = d;
    reqSel[r*2 +: 2]    = s;
  endtask

  // Waits (bounded) for requester r's handshake, returns at cycle 1 of the txn.
  task automatic wait_accept(input int r, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (reqValid[r] && reqReady[r]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!busy && reqDone == 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b required idle", name, busy);
    end
  endtask

  // Observes one transaction from cycle 1 until the cycle after reqDone.
  task automatic watch(input int chain, output logic [23:0] word, output int nbits,
                       output int le_first, output int le_last, output int done_cyc,
                       output logic [1:0] done_bits, output int done_count,
                       output int busy_low, output bit other_active, output bit sdi_glitch);
    logic [1:0] prev_clk;
    logic [1:0] prev_sdi;
    word = '0; nbits = 0; le_first = -1; le_last = -1; done_cyc = -1;
    done_bits = '0; done_count = 0; busy_low = -1; other_active = 1'b0;
    sdi_glitch = 1'b0; prev_clk = '0; prev_sdi = '0;
    for (int c = 1; c <= 150; c++) begin
      for (int j = 0; j < 2; j++) begin
        if (j == chain) begin
          if (spiClk[j] && !prev_clk[j]) begin
            word  = {word[22:0], spiSdi[j]};
            nbits = nbits + 1;
          end
          if (spiLe[j]) begin
            if (le_first < 0) le_first = c;
            le_last = c;
          end
        end else if (spiClk[j] || spiSdi[j] || spiLe[j]) begin
          other_active = 1'b1;
        end
        if (spiClk[j] && prev_clk[j] && (spiSdi[j] !== prev_sdi[j])) sdi_glitch = 1'b1;
      end
      if (reqDone != 2'b00) begin
        done_cyc   = c;
        done_bits  = reqDone;
        done_count = done_count + 1;
      end
      if (!busy && busy_low < 0) busy_low = c;
      prev_clk = spiClk;
      prev_sdi = spiSdi;
      if (done_cyc > 0 && c == done_cyc + 1) break;
      tick();
    end
  endtask

  task automatic test_reset();
    sysReset = 1'b1;
    reqValid = 2'b11;
    reqData  = '0;
    reqSel   = '0;
    tick(); tick(); tick();
    checks++;
    if (reqReady !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b required 00", reqReady); end
    checks++;
    if ({reqDone, busy, selError} !== 4'b0) begin
      errors++; $display("FAIL reset_status: done=%b busy=%b selError=%b required 0", reqDone, busy, selError);
    end
    checks++;
    if ({spiClk, spiSdi, spiLe} !== 6'b0) begin
      errors++; $display("FAIL reset_pins: clk=%b sdi=%b le=%b required 0", spiClk, spiSdi, spiLe);
    end
    sysReset = 1'b0;
    reqValid = 2'b00;
    tick();
  endtask

  task automatic test_single();
    bit ok; logic [23:0] word; int nbits, lf, ll, dc, dn, bl; logic [1:0] db; bit oth, gl;
    set_req(0, 24'hA5C3F0, 2'd1);
    reqValid = 2'b01;
    #1;
    checks++;
    if (reqReady !== 2'b01) begin errors++; $display("FAIL single_ready: got %b required 01", reqReady); end
    wait_accept(0, ok);
    reqValid = 2'b00;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: got no accept required accept"); end
    watch(1, word, nbits, lf, ll, dc, db, dn, bl, oth, gl);
    checks++;
    if (nbits != 24 || word !== 24'hA5C3F0) begin
      errors++; $display("FAIL single_word: got %h (%0d bits) required a5c3f0 (24 bits)", word, nbits);
    end
    checks++;
    if (lf != 99 || ll != 100) begin errors++; $display("FAIL single_le: got %0d..%0d required 99..100", lf, ll); end
    checks++;
    if (dc != 102 || db !== 2'b01 || dn != 1) begin
      errors++; $display("FAIL single_done: got cycle %0d bits %b count %0d required 102 01 1", dc, db, dn);
    end
    checks++;
    if (bl != 103) begin errors++; $display("FAIL single_busy: got drop at %0d required 103", bl); end
    checks++;
    if (oth) begin errors++; $display("FAIL single_chain0: got activity required none"); end
    checks++;
    if (gl) begin errors++; $display("FAIL single_sdi_stable: got change while clk high required none"); end
  endtask

  task automatic test_contention();
    logic [1:0] acc_bits [4]; int acc_s [4]; logic [1:0] done_bits [4]; int done_s [4];
    int nacc, ndone; logic [1:0] acc;
    nacc = 0; ndone = 0;
    sysReset = 1'b1; reqValid = 2'b00;
    tick(); tick();
    set_req(0, 24'h111111, 2'd0);
    set_req(1, 24'h222222, 2'd1);
    sysReset = 1'b0;
    reqValid = 2'b11;
    for (int s = 0; s < 500 && ndone < 4; s++) begin
      #1;
      acc = reqValid & reqReady;
      if (acc != 2'b00 && nacc < 4) begin acc_bits[nacc] = acc; acc_s[nacc] = s; nacc++; end
      if (reqDone != 2'b00 && ndone < 4) begin done_bits[ndone] = reqDone; done_s[ndone] = s; ndone++; end
      tick();
      if (nacc == 4) reqValid = 2'b00;
    end
    reqValid = 2'b00;
    checks++;
    if (nacc != 4 || ndone != 4) begin
      errors++; $display("FAIL contention_count: got %0d accepts %0d dones required 4 4", nacc, ndone);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_bits[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL contention_order%0d: got %b required %b", i, acc_bits[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        checks++;
        if (acc_s[i] - acc_s[0] != 103 * i) begin
          errors++; $display("FAIL contention_spacing%0d: got %0d required %0d", i, acc_s[i] - acc_s[0], 103 * i);
        end
        checks++;
        if (done_bits[i] !== acc_bits[i] || done_s[i] - acc_s[i] != 102) begin
          errors++; $display("FAIL contention_done%0d: got %b after %0d required %b after 102",
                             i, done_bits[i], done_s[i] - acc_s[i], acc_bits[i]);
        end
      end
    end
    wait_idle("contention");
  endtask

  task automatic test_fairness();
    bit ok; logic [1:0] acc_bits [3]; int acc_s [3]; int nacc; logic [1:0] acc;
    nacc = 0;
    set_req(0, 24'h0000FF, 2'd0);
    set_req(1, 24'hFF0000, 2'd1);
    reqValid = 2'b01;
    wait_accept(0, ok);
    reqValid = 2'b00;
    checks++;
    if (!ok) begin errors++; $display("FAIL fairness_first_accept: got none required accept"); end
    wait_idle("fairness_a");
    reqValid = 2'b10;
    for (int s = 0; s < 400 && nacc < 3; s++) begin
      #1;
      acc = reqValid & reqReady;
      if (acc != 2'b00) begin acc_bits[nacc] = acc; acc_s[nacc] = s; nacc++; end
      tick();
      if (acc[0]) reqValid[0] = 1'b0;
      if (s == 10 || s == 30) reqValid[0] = 1'b1;
      if (s == 15) reqValid[0] = 1'b0;
    end
    reqValid = 2'b00;
    checks++;
    if (nacc != 3) begin
      errors++; $display("FAIL fairness_count: got %0d accepts required 3", nacc);
    end else begin
      checks++;
      if (acc_bits[0] !== 2'b10 || acc_bits[1] !== 2'b01 || acc_bits[2] !== 2'b10) begin
        errors++; $display("FAIL fairness_order: got %b %b %b required 10 01 10", acc_bits[0], acc_bits[1], acc_bits[2]);
      end
      checks++;
      if (acc_s[1] - acc_s[0] != 103 || acc_s[2] - acc_s[0] != 206) begin
        errors++; $display("FAIL fairness_timing: got %0d %0d required 103 206", acc_s[1] - acc_s[0], acc_s[2] - acc_s[0]);
      end
    end
    wait_idle("fairness_b");
  endtask

  task automatic test_reset_mid();
    bit ok; int ndone; logic [23:0] word; int nbits, lf, ll, dc, dn, bl; logic [1:0] db; bit oth, gl;
    set_req(0, 24'h3C3C3C, 2'd0);
    reqValid = 2'b01;
    wait_accept(0, ok);
    reqValid = 2'b00;
    for (int c = 1; c < 40; c++) tick();
    checks++;
    if (!ok || busy !== 1'b1) begin errors++; $display("FAIL rstmid_inflight: got busy=%b required 1", busy); end
    sysReset = 1'b1;
    tick();
    checks++;
    if ({spiClk, spiSdi, spiLe} !== 6'b0) begin
      errors++; $display("FAIL rstmid_pins: clk=%b sdi=%b le=%b required 0", spiClk, spiSdi, spiLe);
    end
    checks++;
    if ({reqDone, reqReady, busy} !== 5'b0) begin
      errors++; $display("FAIL rstmid_status: done=%b ready=%b busy=%b required 0", reqDone, reqReady, busy);
    end
    sysReset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (reqDone != 2'b00) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d strobes required 0", ndone); end
    set_req(1, 24'h800001, 2'd0);
    reqValid = 2'b10;
    wait_accept(1, ok);
    reqValid = 2'b00;
    watch(0, word, nbits, lf, ll, dc, db, dn, bl, oth, gl);
    checks++;
    if (!ok || word !== 24'h800001 || nbits != 24 || dc != 102 || db !== 2'b10) begin
      errors++; $display("FAIL rstmid_after: got word %h bits %0d done %0d/%b required 800001 24 102/10", word, nbits, dc, db);
    end
  endtask

  task automatic test_invalid_sel();
    bit ok; logic [23:0] word; int nbits, lf, ll, dc, dn, bl; logic [1:0] db; bit oth, gl;
    checks++;
    if (selError !== 1'b0) begin errors++; $display("FAIL badsel_pre: got %b required 0", selError); end
    set_req(0, 24'hFFFFFF, 2'd3);
    reqValid = 2'b01;
    wait_accept(0, ok);
    reqValid = 2'b00;
    watch(2, word, nbits, lf, ll, dc, db, dn, bl, oth, gl);
    checks++;
    if (!ok || oth) begin errors++; $display("FAIL badsel_pins: got activity=%b accept=%b required 0 1", oth, ok); end
    checks++;
    if (dc != 102 || db !== 2'b01) begin errors++; $display("FAIL badsel_done: got %0d/%b required 102/01", dc, db); end
    checks++;
    if (selError !== 1'b1) begin errors++; $display("FAIL badsel_flag: got %b required 1", selError); end
    set_req(1, 24'h123456, 2'd1);
    reqValid = 2'b10;
    wait_accept(1, ok);
    reqValid = 2'b00;
    watch(1, word, nbits, lf, ll, dc, db, dn, bl, oth, gl);
    checks++;
    if (!ok || word !== 24'h123456 || selError !== 1'b1) begin
      errors++; $display("FAIL badsel_sticky: got word %h selError %b required 123456 1", word, selError);
    end
    sysReset = 1'b1;
    tick();
    sysReset = 1'b0;
    checks++;
    if (selError !== 1'b0) begin errors++; $display("FAIL badsel_clear: got %b required 0", selError); end
  endtask

  task automatic test_data_stability();
    bit ok; logic [23:0] word; int nbits, lf, ll, dc, dn, bl; logic [1:0] db; bit oth, gl;
    set_req(1, 24'h5AC3E7, 2'd0);
    reqValid = 2'b10;
    wait_accept(1, ok);
    reqValid = 2'b00;
    set_req(1, 24'h000000, 2'd1);
    watch(0, word, nbits, lf, ll, dc, db, dn, bl, oth, gl);
    checks++;
    if (!ok || word !== 24'h5AC3E7 || nbits != 24) begin
      errors++; $display("FAIL stable_word: got %h (%0d bits) required 5ac3e7 (24 bits)", word, nbits);
    end
    checks++;
    if (gl) begin errors++; $display("FAIL stable_sdi: got change while clk high required none"); end
    checks++;
    if (oth) begin errors++; $display("FAIL stable_sel: got chain 1 activity required none"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_invalid_sel();
    test_data_stability();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afe_spi_sequencer.md
Name: afe_spi_sequencer

Overview:
- Shares the two AFE attenuator/switch SPI chains (AFE_SPI_CLK/SDI/LE[1:0]) between several write requesters, e.g. the CSR path from the processor and the autotrim/calibration engine.
- A round-robin arbiter grants one request at a time. A serializer then shifts the word MSB-first to the selected chain and pulses the latch enable.
- Sits in the sysClk domain between the requesters and the top-level AFE_SPI pins. Write-only; no readback.

Parameters:
- NREQ, 2, number of requesters (1..8).
- NSPI, 2, number of SPI chains driven.
- SEL_WIDTH, 1, chain-select width; must be ≥ clog2(NSPI), minimum 1.
- DATA_WIDTH, 24, bits per transaction (8..32).
- CLK_DIV, 10, sysClk cycles per SPI half-period (≥1).

Ports:
- sysClk  in  1  system clock; all logic is on its rising edge.
- sysReset  in  1  synchronous, active-high reset.
- reqValid  in  NREQ  per-requester request valid.
- reqReady  out  NREQ  one-hot grant; accept = reqValid[i] & reqReady[i].
- reqData  in  NREQ*DATA_WIDTH  word for requester i in slice i.
- reqSel  in  NREQ*SEL_WIDTH  target chain for requester i.
- reqDone  out  NREQ  one-cycle strobe to the requester whose transaction finished.
- busy  out  1  high from accept until the cycle after reqDone.
- selError  out  1  sticky; set on an accepted reqSel ≥ NSPI; cleared by reset only.
- spiClk  out  NSPI  SPI clock; idles low.
- spiSdi  out  NSPI  SPI data.
- spiLe  out  NSPI  latch enable, active high.

Behaviour:
- Reset values: reqReady, reqDone, busy, selError, spiClk, spiSdi and spiLe all 0. Round-robin pointer set so requester 0 has highest priority.
- All outputs are registered. Lines of unselected chains stay 0 at all times.
- States and transitions:
  - IDLE: reqReady is combinationally one-hot for the highest-priority valid requester, searching from (last granted + 1) mod NREQ. On accept, capture data and sel, advance the pointer, set busy, go to LOW.
  - LOW: spiClk=0, spiSdi = current bit, for CLK_DIV cycles, then go to HIGH.
  - HIGH: spiClk=1 for CLK_DIV cycles. If bits remain, shift and go to LOW; otherwise go to HOLD.
  - HOLD: clk=0, sdi=0 for CLK_DIV cycles.
  - LATCH: spiLe=1 for CLK_DIV cycles.
  - GAP: all lines 0 for CLK_DIV cycles. reqDone pulses on the last GAP cycle, then go to IDLE.
- reqReady is 0 in every state other than IDLE.
- Timing, with accept at cycle 0:
  - Bit k (k=0 is the MSB) has LOW starting at cycle 1+2k·CLK_DIV and HIGH starting at 1+(2k+1)·CLK_DIV.
  - reqDone fires at cycle (2·DATA_WIDTH+3)·CLK_DIV.
  - busy drops the cycle after reqDone.
  - The earliest next accept is the cycle after reqDone (one IDLE cycle).
- spiSdi changes only while spiClk is low. It is stable for CLK_DIV cycles before every rising edge and for CLK_DIV cycles after it.
- Invalid chain (sel ≥ NSPI): the full sequence still runs with no pin toggling, reqDone is still issued, and selError is set.
- reqValid dropped before grant: the request is ignored and the pointer is unchanged.
- A requester holding reqValid continuously is re-granted only after every other pending requester has been served.
- Changes to reqData/reqSel after accept have no effect on the transaction in flight.
- Reset mid-transaction: the next cycle has all outputs 0 and state IDLE. The transaction is abandoned and no reqDone is issued.
- NREQ=1: the arbiter degenerates to a pass-through with the same timing.

Decomposition:
- Shared package/header afe_spi_pkg holds:
  - the state encoding (IDLE, LOW, HIGH, HOLD, LATCH, GAP);
  - the clog2 helper;
  - the DATA_WIDTH and CLK_DIV range limits.
- One sub-module, rr_arbiter: parameter NREQ, inputs req and advance, one-hot grant output, pointer register. It is reusable by other shared-resource blocks.
- The half-period counter, bit counter and shift register stay in afe_spi_sequencer.

Test Plan:
- Single transaction (CLK_DIV=2, DATA_WIDTH=24): req0, data 0xA5C3F0, sel 1.
  - spiSdi[1] sampled on the 24 spiClk[1] rising edges yields 0xA5C3F0.
  - spiLe[1] is high on cycles 99–100.
  - reqDone[0] fires on cycle 102.
  - Chain 0 pins stay 0 throughout.
- Contention: req0 and req1 valid in the same cycle from reset.
  - Grant order is 0, 1, 0, 1.
  - Accepts are 103 cycles apart.
  - Each reqDone lands on its own requester's bit.
- Fairness: req1 held valid continuously, req0 pulsed during req1's transaction.
  - req0 is granted next, before req1's second grant.
- Reset mid-shift: assert sysReset at cycle 40 of a transaction.
  - All outputs are 0 the next cycle and no reqDone is issued.
  - A new request after reset completes normally.
- Invalid select (NSPI=2, SEL_WIDTH=2): sel=3.
  - No pin toggles and reqDone appears at the nominal cycle.
  - selError=1 and stays set until reset.
- Data stability: change reqData the cycle after accept.
  - Shifted bits still match the captured value.
  - spiSdi never changes while spiClk=1.
